// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for a 4:1 mux: steps the selects through channels 0..3, samples
// data_in at the end of each settle window and reports the 4-bit word with a done pulse.
module mux_scan_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter bit          AUTO_RESTART  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       data_in,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       done,
  output logic [3:0] word_out,
  output logic [1:0] dbg_state
);

  // start is a level request sampled only in IDLE (no ready back-pressure);
  // done is a single-cycle strobe and word_out is valid from that cycle until the next done.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [3:0] shadow_q, shadow_d;
  logic [3:0] word_q, word_d;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    wait_cnt_d = wait_cnt_q;
    shadow_d   = shadow_q;
    word_d     = word_q;
    case (state_q)
      ST_IDLE: begin
        sel_d      = 2'd0;
        wait_cnt_d = 4'd0;
        if (start) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (wait_cnt_q < SETTLE) begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end else begin
          // Last edge of this channel's window: capture and move on.
          wait_cnt_d       = 4'd0;
          shadow_d[sel_q]  = data_in;
          if (sel_q == 2'd3) begin
            state_d = ST_DONE;
            word_d  = {data_in, shadow_q[2:0]};
            sel_d   = 2'd0;
          end else begin
            sel_d = sel_q + 2'd1;
          end
        end
      end
      ST_DONE: begin
        sel_d      = 2'd0;
        wait_cnt_d = 4'd0;
        state_d    = AUTO_RESTART ? ST_SCAN : ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        sel_d      = 2'd0;
        wait_cnt_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= 2'd0;
      wait_cnt_q <= 4'd0;
      shadow_q   <= 4'd0;
      word_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      wait_cnt_q <= wait_cnt_d;
      shadow_q   <= shadow_d;
      word_q     <= word_d;
    end
  end

  // sel_q is forced to 0 outside SCAN, so the selects need no extra gating.
  assign s0        = sel_q[0];
  assign s1        = sel_q[1];
  assign busy      = (state_q == ST_SCAN);
  assign done      = (state_q == ST_DONE);
  assign word_out  = word_q;
  assign dbg_state = state_q;

endmodule
